// File: rtl/lsu_misalign_unit.sv
// Load/store sequencer between EX/MEM and datamemory: word-read loads, per-lane stores.
// Build option MISALIGN_SPLIT_EN: split misaligned accesses; otherwise reject them with misalign_err.
module lsu_misalign_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  misalign_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, RESP, WR, WR_B, ERR} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q, lo_q, hi_q;
  logic [2:0]            funct3_q;
  logic                  accept;
  logic [DM_ADDRESS-1:0] word_a;
  logic [DATA_W-1:0]     shifted;

  // Index of the last byte of the access (size - 1); size comes from funct3[1:0] alone.
  function automatic logic [1:0] last_k(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic spans_words(input logic [1:0] off, input logic [2:0] f3);
    return ({1'b0, off} + {1'b0, last_k(f3)}) > 3'd3;
  endfunction

  assign accept  = (state_q == IDLE) && req_valid && (req_read || req_write);
  assign word_a  = {addr_q[DM_ADDRESS-1:2], 2'b00};
  assign shifted = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});

  // NOTE: request fields and read data are captured with non-blocking assignments so every
  // register samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (state_q == RD_LO) lo_q <= mem_rd;
      if (state_q == RD_HI) hi_q <= mem_rd;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall        = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    misalign_err = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_a        = '0;
    mem_wd       = '0;
    mem_funct3   = '0;
    case (state_q)
      IDLE: begin
        stall = accept;
        cnt_d = 2'd0;
        if (accept) begin
`ifdef MISALIGN_SPLIT_EN
          if (req_read)                                      state_d = RD_LO;
          else if (is_misaligned(req_addr[1:0], req_funct3)) state_d = WR_B;
          else                                               state_d = WR;
`else
          if (is_misaligned(req_addr[1:0], req_funct3))      state_d = ERR;
          else if (req_read)                                 state_d = RD_LO;
          else                                               state_d = WR;
`endif
        end
      end
      RD_LO: begin
        stall      = 1'b1;
        mem_read   = 1'b1;
        mem_a      = word_a;
        mem_funct3 = 3'b010;
        state_d    = spans_words(addr_q[1:0], funct3_q) ? RD_HI : RESP;
      end
      RD_HI: begin
        stall      = 1'b1;
        mem_read   = 1'b1;
        mem_a      = word_a + DM_ADDRESS'(4);
        mem_funct3 = 3'b010;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        case (funct3_q)
          3'b000:  resp_rdata = {{24{shifted[7]}}, shifted[7:0]};
          3'b100:  resp_rdata = {24'b0, shifted[7:0]};
          3'b001:  resp_rdata = {{16{shifted[15]}}, shifted[15:0]};
          3'b101:  resp_rdata = {16'b0, shifted[15:0]};
          default: resp_rdata = shifted;
        endcase
        state_d = IDLE;
      end
      WR: begin
        mem_write  = 1'b1;
        mem_a      = addr_q;
        mem_wd     = wdata_q;
        mem_funct3 = funct3_q;
        state_d    = IDLE;
      end
      WR_B: begin
        mem_write  = 1'b1;
        mem_a      = addr_q + DM_ADDRESS'(cnt_q);
        mem_wd     = {4{wdata_q[{cnt_q, 3'b000} +: 8]}};
        mem_funct3 = 3'b000;
        if (cnt_q == last_k(funct3_q)) begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 2'd1;
        end
      end
      ERR: begin
`ifdef MISALIGN_SPLIT_EN
        misalign_err = 1'b0;
`else
        misalign_err = 1'b1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_misalign_unit.sv
// Directed bench for lsu_misalign_unit with a byte-array datamemory model and
// response/write scoreboards; split-build cases are selected by MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module tb_lsu_misalign_unit;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_read, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_funct3;
  logic          stall, resp_valid, misalign_err, mem_read, mem_write;
  logic [31:0]   resp_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;
  logic [2:0]    mem_funct3;

  lsu_misalign_unit #(.DM_ADDRESS(AW), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign_err(misalign_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // datamemory model: combinational word read, lane writes on the rising edge.
  logic [7:0]    mem [512];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [31:0]   pre_d = '0;

  assign mem_rd = {mem[{mem_a[AW-1:2], 2'b11}], mem[{mem_a[AW-1:2], 2'b10}],
                   mem[{mem_a[AW-1:2], 2'b01}], mem[{mem_a[AW-1:2], 2'b00}]};

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++) mem[pre_a + AW'(i)] <= pre_d[8*i +: 8];
    end else if (mem_write) begin
      for (int i = 0; i < 4; i++)
        if (i < nbytes(mem_funct3)) mem[mem_a + AW'(i)] <= mem_wd[8*i +: 8];
    end
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic [2:0]    f3;
  } wr_t;

  logic [31:0] exp_resp [$];
  wr_t         exp_wr [$];
  int errors = 0, checks = 0;
  int rd_cnt = 0, err_cnt = 0, resp_cnt = 0, wr_cnt = 0;
  int rd_before, resp_before, wr_before;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read) rd_cnt++;
      if (misalign_err) err_cnt++;
      if (resp_valid || misalign_err)
        check("resp_err_exclusive", 32'(resp_valid & misalign_err), 32'd0);
      if (resp_valid) begin
        resp_cnt++;
        if (exp_resp.size() == 0) check("resp_unexpected", 32'(resp_valid), 32'd0);
        else check("resp_data", resp_rdata, exp_resp.pop_front());
      end
      if (mem_write) begin
        wr_t w;
        wr_cnt++;
        if (exp_wr.size() == 0) check("wr_unexpected", 32'(mem_write), 32'd0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(mem_a), 32'(w.a));
          check("wr_data", mem_wd, w.wd);
          check("wr_funct3", 32'(mem_funct3), 32'(w.f3));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] wd, input logic [2:0] f3);
    wr_t w;
    w.a = a; w.wd = wd; w.f3 = f3;
    exp_wr.push_back(w);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp"}, {31'b0, resp_valid} | resp_rdata, 32'd0);
    check({tag, "_err"}, 32'(misalign_err), 32'd0);
    check({tag, "_memctl"}, {30'b0, mem_read, mem_write}, 32'd0);
    check({tag, "_mem_a"}, 32'(mem_a), 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
    check({tag, "_mem_f3"}, 32'(mem_funct3), 32'd0);
  endtask

  // Presents a request in IDLE (cycle T), checks the combinational stall, returns in T+1.
  task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = a; req_wdata = wd; req_funct3 = f3;
    #1 check("stall_accept", 32'(stall), 32'd1);
    step();
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [2:0] f3,
                         input logic [31:0] exp, input int lat);
    logic [AW-1:0] wa;
    wa = {a[AW-1:2], 2'b00};
    exp_resp.push_back(exp);
    issue(1'b1, 1'b0, a, 32'h0, f3);
    for (int i = 1; i < lat; i++) begin
      check("ld_read", 32'(mem_read), 32'd1);
      check("ld_addr", 32'(mem_a), 32'(wa + AW'(4 * (i - 1))));
      check("ld_stall", 32'(stall), 32'd1);
      step();
    end
    check("ld_resp_valid", 32'(resp_valid), 32'd1);
    check("ld_resp_stall", 32'(stall), 32'd0);
    step();
    check("ld_resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input int n);
    issue(1'b0, 1'b1, a, wd, f3);
    for (int k = 0; k < n; k++) begin
      check("st_write", 32'(mem_write), 32'd1);
      check("st_stall", 32'(stall), (k == n - 1) ? 32'd0 : 32'd1);
      step();
    end
    check("st_done", 32'(mem_write), 32'd0);
  endtask

  initial begin
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    step();

    // Aligned loads of every width.
    preload(9'h010, 32'hDEADBEEF);
    do_load(9'h010, 3'b010, 32'hDEADBEEF, 2);
    do_load(9'h012, 3'b001, 32'hFFFFDEAD, 2);
    do_load(9'h012, 3'b101, 32'h0000DEAD, 2);
    do_load(9'h011, 3'b000, 32'hFFFFFFBE, 2);
    do_load(9'h013, 3'b100, 32'h000000DE, 2);

    // Aligned stores, then read back.
    push_wr(9'h020, 32'h11223344, 3'b010);
    do_store(9'h020, 32'h11223344, 3'b010, 1);
    do_load(9'h020, 3'b010, 32'h11223344, 2);
    push_wr(9'h021, 32'h000000AA, 3'b000);
    do_store(9'h021, 32'h000000AA, 3'b000, 1);
    push_wr(9'h022, 32'h00005566, 3'b001);
    do_store(9'h022, 32'h00005566, 3'b001, 1);
    do_load(9'h020, 3'b010, 32'h5566AA44, 2);

    // Reset during a load aborts it, then the unit recovers.
    issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    check("abort_ld_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1 check_zero("abort_ld");
    step();
    rst_n = 1'b1;
    step();
    do_load(9'h010, 3'b010, 32'hDEADBEEF, 2);

`ifdef MISALIGN_SPLIT_EN
    // Spanning and non-spanning misaligned loads.
    preload(9'h00C, 32'h44332211);
    preload(9'h010, 32'h88776655);
    do_load(9'h00E, 3'b010, 32'h66554433, 3);
    preload(9'h000, 32'h80AABBCC);
    preload(9'h004, 32'h000000FE);
    do_load(9'h003, 3'b001, 32'hFFFFFE80, 3);
    do_load(9'h003, 3'b101, 32'h0000FE80, 3);
    do_load(9'h001, 3'b001, 32'hFFFFAABB, 2);
    do_load(9'h001, 3'b010, 32'hFE80AABB, 3);

    // Misaligned stores split into byte writes, including address wrap.
    preload(9'h1FC, 32'hA0A1A2A3);
    push_wr(9'h1FE, 32'h44444444, 3'b000);
    push_wr(9'h1FF, 32'h33333333, 3'b000);
    push_wr(9'h000, 32'h22222222, 3'b000);
    push_wr(9'h001, 32'h11111111, 3'b000);
    do_store(9'h1FE, 32'h11223344, 3'b010, 4);
    do_load(9'h1FC, 3'b010, 32'h3344A2A3, 2);
    do_load(9'h000, 3'b010, 32'h80AA1122, 2);
    push_wr(9'h021, 32'hEFEFEFEF, 3'b000);
    push_wr(9'h022, 32'hBEBEBEBE, 3'b000);
    do_store(9'h021, 32'h0000BEEF, 3'b001, 2);
    do_load(9'h020, 3'b010, 32'h55BEEF44, 2);

    // Reset after the second byte of a wrapping store.
    preload(9'h1FC, 32'hA0A1A2A3);
    preload(9'h000, 32'hB0B1B2B3);
    push_wr(9'h1FE, 32'h44444444, 3'b000);
    push_wr(9'h1FF, 32'h33333333, 3'b000);
    issue(1'b0, 1'b1, 9'h1FE, 32'h11223344, 3'b010);
    check("rst_st_w0", 32'(mem_write), 32'd1);
    step();
    check("rst_st_w1", 32'(mem_write), 32'd1);
    step();
    wr_before = wr_cnt;
    rst_n = 1'b0;
    #1 check_zero("abort_st");
    step();
    rst_n = 1'b1;
    step();
    check("rst_st_no_more_writes", 32'(wr_cnt), 32'(wr_before));
    do_load(9'h1FC, 3'b010, 32'h3344A2A3, 2);
    do_load(9'h000, 3'b010, 32'hB0B1B2B3, 2);
`else
    // Misaligned requests are rejected without touching memory.
    rd_before = rd_cnt;
    resp_before = resp_cnt;
    issue(1'b1, 1'b0, 9'h001, 32'h0, 3'b010);
    check("rej_ld_err", 32'(misalign_err), 32'd1);
    check("rej_ld_stall", 32'(stall), 32'd0);
    check("rej_ld_read", 32'(mem_read), 32'd0);
    step();
    check("rej_ld_err_pulse", 32'(misalign_err), 32'd0);
    step();
    check("rej_ld_no_reads", 32'(rd_cnt), 32'(rd_before));
    check("rej_ld_no_resp", 32'(resp_cnt), 32'(resp_before));
    check("rej_ld_err_count", 32'(err_cnt), 32'd1);

    wr_before = wr_cnt;
    issue(1'b0, 1'b1, 9'h022, 32'hCAFEF00D, 3'b010);
    check("rej_st_err", 32'(misalign_err), 32'd1);
    check("rej_st_write", 32'(mem_write), 32'd0);
    step();
    check("rej_st_err_pulse", 32'(misalign_err), 32'd0);
    step();
    check("rej_st_no_writes", 32'(wr_cnt), 32'(wr_before));
    do_load(9'h020, 3'b010, 32'h5566AA44, 2);
`endif

    step();
    check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_misalign_unit.md
# lsu_misalign_unit

Load/store sequencer between the EX/MEM pipeline register and `datamemory`. It accepts one memory request per instruction and handles RV32 load/store semantics, including misaligned accesses, using only memory operations that `datamemory` supports natively:
- word-aligned LW reads;
- per-lane SB/SH/SW writes.

It stalls the pipeline while a multi-cycle access is in flight, and returns load data to the MEM/WB stage.

## Interface
Parameters:
- `DM_ADDRESS`, 9: byte-address width of data memory.
- `DATA_W`, 32: data width. Only 32 is supported.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present from EX/MEM.
- `req_read` in 1: load (MemRead).
- `req_write` in 1: store (MemWrite). If both `req_read` and `req_write` are set, read wins.
- `req_addr` in `DM_ADDRESS`: byte address (ALU result LSBs).
- `req_wdata` in `DATA_W`: store data.
- `req_funct3` in 3: instruction bits 14:12.
- `stall` out 1: freeze upstream pipeline.
- `resp_valid` out 1: load result valid (one-cycle pulse).
- `resp_rdata` out `DATA_W`: extended load result.
- `misalign_err` out 1: misaligned access rejected (one-cycle pulse).
- `mem_read`, `mem_write` out 1: to `datamemory` MemRead/MemWrite.
- `mem_a` out `DM_ADDRESS`: to `datamemory` a.
- `mem_wd` out `DATA_W`: to `datamemory` wd.
- `mem_funct3` out 3: to `datamemory` Funct3.
- `mem_rd` in `DATA_W`: `datamemory` rd. Valid in the same cycle `mem_read`/`mem_a` are driven (combinational read).

## Operation
- **Access size** from funct3:
  - 000/100 → 1 byte.
  - 001/101 → 2 bytes.
  - 010 and all others → 4 bytes, treated as LW/SW.
- **Misaligned** means size 2 with `addr[0]=1`, or size 4 with `addr[1:0]≠0`.
- **States:** IDLE, RD_LO, RD_HI, RESP, WR, WR_B, ERR.
- **IDLE:** a request is accepted when `req_valid` && (`req_read` || `req_write`). All request fields are registered on accept.
- **Load (misaligned or not), word reads only:**
  - RD_LO drives `mem_read=1`, `mem_a={addr[DM_ADDRESS-1:2],2'b00}`, `mem_funct3=010`, and captures `mem_rd` as `lo`.
  - If offset+size > 4, the unit goes to RD_HI: `mem_a = lo address + 4`, modulo 2^DM_ADDRESS (wraps to 0). It captures `mem_rd` as `hi`.
  - Otherwise the unit goes straight to RESP.
- **RESP:**
  - Data is `({hi,lo} >> 8*addr[1:0])`, truncated to the access size.
  - 000/001 sign-extend; 100/101 zero-extend; word is passed through.
  - `resp_valid=1`, then the unit returns to IDLE.
- **Aligned store:** WR drives `mem_write=1`, `mem_a=addr`, `mem_wd=wdata`, `mem_funct3=funct3` for one cycle, then IDLE.
- **Misaligned store:** WR_B issues `size` byte stores, k = 0…size-1:
  - `mem_a = addr+k`, modulo 2^DM_ADDRESS.
  - `mem_funct3=000`.
  - `mem_wd = {4{wdata[8k+7:8k]}}`.
  - A 2-bit counter steps k; the unit returns to IDLE after the last byte.
- **`stall`:**
  - Combinationally 1 in IDLE when a request is accepted.
  - 1 in RD_LO, RD_HI, and every WR_B cycle except the last.
  - 0 in RESP, WR, the last WR_B cycle, and ERR.
- **Memory-side outputs** are 0 in any state that does not drive them.

## Timing
- **Reset:**
  - state=IDLE and the byte counter is 0.
  - `stall` follows its IDLE equation and is therefore 0 while `req_valid` is low.
  - All other outputs are 0, including `resp_rdata`.
- **Load latency** (accept cycle T):
  - Aligned or non-spanning: RESP at T+2.
  - Spanning: RESP at T+3.
- **Store occupancy:** aligned WR at T+1. Misaligned: writes at T+1…T+size.
- No new request is accepted outside IDLE. Request inputs are ignored while busy; the pipeline is frozen by `stall`.
- Reset asserted mid-operation aborts immediately. No further `mem_write` occurs; bytes already written stay written.
- `resp_valid` and `misalign_err` are never high together, and each is high for exactly one cycle per request.

## Configuration
- **`MISALIGN_SPLIT_EN` defined:** misaligned accesses are split as described above, and `misalign_err` is tied to 0.
- **`MISALIGN_SPLIT_EN` undefined:** a misaligned request goes IDLE→ERR.
  - ERR raises `misalign_err=1` for one cycle, with no memory access and no `resp_valid`, then returns to IDLE.
  - Aligned requests behave identically in both builds.

## Test plan
- **Aligned LW:** word[0x010]=0xDEADBEEF, LW a=0x010 at T.
  - `mem_a=0x010` at T+1.
  - `resp_rdata=0xDEADBEEF` with `resp_valid` at T+2.
  - `stall` = 1,1,0 over T..T+2.
- **Spanning LW** (split build): word[0x00C]=0x44332211, word[0x010]=0x88776655, LW a=0x00E.
  - `mem_a` = 0x00C then 0x010.
  - `resp_rdata=0x66554433` at T+3.
- **Spanning LH/LHU** (split build): word[0x000]=0x80AABBCC, word[0x004]=0x000000FE.
  - LH a=0x003 → 0xFFFFFE80.
  - LHU a=0x003 → 0x0000FE80.
- **Wrapping SW** (split build): SW a=0x1FE, wd=0x11223344 gives four SB writes:
  - (0x1FE, 0x44444444), (0x1FF, 0x33333333), (0x000, 0x22222222), (0x001, 0x11111111).
  - `stall` is low only on the 4th write.
- **Reset mid-store:** same SW as above, `rst_n` low after the 2nd byte.
  - No further `mem_write`.
  - All outputs 0 and state IDLE.
  - Words then read back show only bytes 0x1FE and 0x1FF modified.
- **Rejected misaligned LW** (non-split build): LW a=0x001.
  - `misalign_err=1` at T+1 only.
  - No `mem_read` at any time, and `resp_valid` stays 0.
